axis_uart_tx: RTL

- AXI-Stream-to-UART transmitter; the transmit side of the UART block, sitting beside the AXIS UART receiver.
- Accepts bytes on an AXIS slave port and serialises each as a UART frame on uart_tx.
- Frame format matches the receiver's sampling layout: start, 8 data bits LSB first, one parity slot, 1 or 2 stop bits.
- Bit timing and frame format come from the same APB register fields that drive the receiver.

---
 rtl/axis_uart_tx.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/axis_uart_tx.sv
// AXI-Stream to UART transmitter: one-byte holding register feeding a start/8-data/parity/stop serialiser.
// Latency: line falls 2 clocks after the accepting edge when idle; frame is 11*div or 12*div clocks.
// Backpressure: saxis_tready_o is low while the holding register is full; it reopens when the byte moves to the shifter.
module axis_uart_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  saxis_tdata_i,
  input  logic        saxis_tvalid_i,
  output logic        saxis_tready_o,
  output logic        uart_tx,
  input  logic [31:0] delitel,
  input  logic        stop_bit_num,
  input  logic [2:0]  parity_bit_mode,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t      state;

  // holding register (one byte deep)
  logic [7:0]  hold_dat;
  logic        hold_vld;

  // per-frame state, latched when a byte is loaded into the shifter
  logic [7:0]  shifter;
  logic        par_bit;
  logic [31:0] div;
  logic        two_stop;

  // slot timing: bit_cnt counts clocks inside a slot, slot_idx counts data/stop slots
  logic [31:0] bit_cnt;
  logic [2:0]  slot_idx;

  logic        accept;
  logic        slot_end;
  logic        last_stop;
  logic        load;
  logic [31:0] div_new;
  logic        par_new;
  logic        line_nxt;

  // handshake, slot boundary and load decisions
  always_comb begin
    accept    = saxis_tvalid_i & saxis_tready_o;
    slot_end  = (bit_cnt == (div - 32'd1));
    last_stop = ~two_stop | slot_idx[0];
    load      = 1'b0;
    if (hold_vld) begin
      if (state == IDLE) begin
        load = 1'b1;
      end else if ((state == STOP) && slot_end && last_stop) begin
        load = 1'b1;
      end
    end
  end

  // frame configuration sampled at load: zero divider behaves as one clock per bit
  always_comb begin
    div_new = (delitel == 32'd0) ? 32'd1 : delitel;
    par_new = 1'b1;
    case (parity_bit_mode)
      3'd0:    par_new = 1'b0;
      3'd1:    par_new = 1'b1;
      3'd2:    par_new = ~^hold_dat;
      3'd3:    par_new = ^hold_dat;
      default: par_new = 1'b1;
    endcase
  end

  // line level implied by the current state; registered into uart_tx one clock later
  always_comb begin
    line_nxt = 1'b1;
    case (state)
      IDLE:    line_nxt = 1'b1;
      START:   line_nxt = 1'b0;
      DATA:    line_nxt = shifter[0];
      PARITY:  line_nxt = par_bit;
      STOP:    line_nxt = 1'b1;
      default: line_nxt = 1'b1;
    endcase
  end

  // holding register, serialiser FSM and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      hold_dat       <= 8'd0;
      hold_vld       <= 1'b0;
      shifter        <= 8'd0;
      par_bit        <= 1'b0;
      div            <= 32'd1;
      two_stop       <= 1'b0;
      bit_cnt        <= 32'd0;
      slot_idx       <= 3'd0;
      uart_tx        <= 1'b1;
      saxis_tready_o <= 1'b1;
      busy_o         <= 1'b0;
    end else begin
      uart_tx <= line_nxt;
      busy_o  <= (state != IDLE);

      // tready mirrors the next value of hold_vld; accept and load never coincide
      if (load) begin
        hold_vld       <= 1'b0;
        saxis_tready_o <= 1'b1;
      end else if (accept) begin
        hold_vld       <= 1'b1;
        hold_dat       <= saxis_tdata_i;
        saxis_tready_o <= 1'b0;
      end else begin
        saxis_tready_o <= ~hold_vld;
      end

      // slot clock counter runs only while a frame is on the line
      if (state == IDLE || slot_end) begin
        bit_cnt <= 32'd0;
      end else begin
        bit_cnt <= bit_cnt + 32'd1;
      end

      if (load) begin
        shifter  <= hold_dat;
        par_bit  <= par_new;
        div      <= div_new;
        two_stop <= stop_bit_num;
        slot_idx <= 3'd0;
        bit_cnt  <= 32'd0;
        state    <= START;
      end else begin
        case (state)
          IDLE: begin
            state <= IDLE;
          end
          START: begin
            if (slot_end) begin
              slot_idx <= 3'd0;
              state    <= DATA;
            end
          end
          DATA: begin
            if (slot_end) begin
              shifter <= {1'b0, shifter[7:1]};
              if (slot_idx == 3'd7) begin
                state <= PARITY;
              end else begin
                slot_idx <= slot_idx + 3'd1;
              end
            end
          end
          PARITY: begin
            if (slot_end) begin
              slot_idx <= 3'd0;
              state    <= STOP;
            end
          end
          STOP: begin
            if (slot_end) begin
              if (last_stop) begin
                state <= IDLE;
              end else begin
                slot_idx <= slot_idx + 3'd1;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
